clk_div_multi: RTL and testbench
================================

// Module: clk_div_multi
// PURPOSE
//   Parametrised multi-channel clock divider. Generates per-channel divided clocks
//   (ceil/floor duty) and one-cycle tick enables from the board clock. Divisors are
//   programmable at runtime with glitch-free update at period boundaries.
//   Channels can be gated individually and phase-aligned together with a sync pulse.
//   Sits between the board oscillator and the slow-rate logic (timers, displays, blinkers).
// PARAMETERS
//   NUM_CH      4            number of independent divider channels (>=1)
//   CNT_W       27           counter/divisor width in bits
//   DEFAULT_DIV 100_000_000  reset divisor P for every channel (100 MHz -> 1 Hz); must be >=2 and fit CNT_W
//   CH_W        (NUM_CH>1)?$clog2(NUM_CH):1   channel-select width (derived, not overridden)
// PORTS
//   clk_100MHZ  in   1       input clock; all logic on posedge
//   rst         in   1       asynchronous, active-high reset
//   en          in   NUM_CH  per-channel count enable
//   sync        in   1       realign all channels to period start
//   cfg_valid   in   1       divisor write request
//   cfg_ch      in   CH_W    target channel for the write
//   cfg_div     in   CNT_W   new divisor P (period in input clocks)
//   cfg_ready   out  1       write accepted when cfg_valid && cfg_ready
//   clk_out     out  NUM_CH  divided clocks, registered
//   tick        out  NUM_CH  one-cycle pulse at each period start, registered
// BEHAVIOUR
//   Reset (async, immediate): div=DEFAULT_DIV, cnt=0, clk_out=0, tick=0, pending=0, cfg_ready=1.
//   Per channel i, P=div[i], H=ceil(P/2); cnt counts 0..P-1 and wraps, only on edges with en[i]=1.
//   - clk_out rises on the edge where cnt goes P-1->0; falls on the edge where cnt goes H-1->H.
//     Steady state: high H cycles, low P-H cycles. No glitches; registered output only.
//   - tick=1 for exactly the cycle after the P-1->0 edge; otherwise 0.
//   - After reset, the first period is entirely low; the first rise and tick follow P enabled edges.
//   - en[i]=0: cnt and clk_out hold their values, tick[i]=0. Period stretches by the disabled cycles.
//   Config handshake:
//   - The write is accepted on an edge with cfg_valid && cfg_ready. cfg_ready then drops for exactly one cycle.
//   - cfg_div<2 is stored as 2.
//   - cfg_ch>=NUM_CH is accepted and ignored.
//   - The accepted value goes to shadow[ch] and pending[ch] is set. A second write before it is applied
//     overwrites the shadow; the last write wins.
//   - Enabled channel: the shadow is loaded into div on the P-1->0 wrap edge, so the new period starts
//     with the new P. The current period always completes with the old P.
//   - Disabled channel: the shadow is loaded on the next edge, with cnt<=0 and clk_out<=0.
//   sync (priority over counting):
//   - On an edge with sync=1, every channel loads any pending divisor and sets cnt<=0.
//   - Enabled channels also set clk_out<=1 and tick<=1. Disabled channels set clk_out<=0 and tick<=0.
//   - A config write accepted on the same edge as sync is not applied by that sync; it waits for the next wrap.
//   Arithmetic: all counters are unsigned CNT_W bits; H is computed as P - (P>>1); no overflow since P<=2^CNT_W-1.
//   Reset mid-operation: all state returns to the reset values immediately, independent of the clock;
//   pending writes are discarded.
// TESTING  (NUM_CH=2, CNT_W=8, DEFAULT_DIV=10)
//   1. Release rst, en=2'b11 -> clk_out low for the first 10 cycles. Then tick pulses every 10 cycles,
//      and clk_out runs 5 high / 5 low, rising with tick.
//   2. Write cfg_ch=1, cfg_div=7 at cnt=3 -> cfg_ready low 1 cycle. Ch1 completes its 10-cycle period,
//      then runs 4 high / 3 low with ticks 7 apart. Ch0 is unchanged.
//   3. Write cfg_div=0 to ch0 -> behaves as P=2: clk_out toggles every cycle, tick every 2nd cycle.
//   4. en[0]=0 for 3 cycles mid-period -> clk_out[0] and cnt hold, tick[0]=0; that period measures 13 cycles.
//   5. Channels at different phases, pulse sync 1 cycle -> next cycle clk_out=2'b11 and tick=2'b11.
//      Both channels stay phase-aligned afterwards.
//   6. Assert rst between clock edges mid-period with a pending write -> clk_out and tick go 0 at once.
//      After release the pending divisor is gone and both channels again show case 1 timing.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider.
// Each channel produces a registered divided clock (high ceil(P/2), low floor(P/2))
// and a one-cycle tick at every period start. Divisor writes go through a shadow
// register. The shadow is loaded at a period boundary, or at once when the channel
// is disabled. A sync pulse realigns every channel to the start of its period.
module clk_div_multi #(
  parameter int  NUM_CH      = 4,
  parameter int  CNT_W       = 27,
  parameter int  DEFAULT_DIV = 100_000_000,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_100MHZ,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic             cfg_ready_q;
  logic             cfg_ready_d;
  logic             cfg_acc;
  logic [CNT_W-1:0] cfg_div_sat;

  // Handshake: an accepted write drops ready for one cycle; divisors below 2 clamp to 2.
  always_comb begin
    cfg_acc     = cfg_valid && cfg_ready_q;
    cfg_ready_d = !cfg_acc;
    cfg_div_sat = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
  end

  // Ready register, high out of reset.
  always_ff @(posedge clk_100MHZ or posedge rst) begin
    if (rst) begin
      cfg_ready_q <= 1'b1;
    end else begin
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign cfg_ready = cfg_ready_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(i);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] half;
    logic             wr_sel;

    // High phase length: ceil(P/2) without needing an extra carry bit.
    assign half   = div_q - (div_q >> 1);
    // Writes to a non-existent channel match no IDX and are dropped.
    assign wr_sel = cfg_acc && (cfg_ch == IDX);

    // Next state: sync beats counting; a disabled channel takes a pending divisor at once.
    always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      shd_d  = shd_q;
      pend_d = pend_q;
      clk_d  = clk_q;
      tick_d = 1'b0;
      if (sync) begin
        if (pend_q) begin
          div_d  = shd_q;
          pend_d = 1'b0;
        end
        cnt_d  = '0;
        clk_d  = en[i];
        tick_d = en[i];
      end else if (en[i]) begin
        if (cnt_q == div_q - ONE) begin
          cnt_d  = '0;
          clk_d  = 1'b1;
          tick_d = 1'b1;
          if (pend_q) begin
            div_d  = shd_q;
            pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + ONE;
          if (cnt_q == half - ONE) begin
            clk_d = 1'b0;
          end
        end
      end else if (pend_q) begin
        div_d  = shd_q;
        pend_d = 1'b0;
        cnt_d  = '0;
        clk_d  = 1'b0;
      end
      // A write on this edge lands in the shadow after any load above, so it waits.
      if (wr_sel) begin
        shd_d  = cfg_div_sat;
        pend_d = 1'b1;
      end
    end

    // Channel state registers with immediate reset to the default divisor.
    always_ff @(posedge clk_100MHZ or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        div_q  <= RST_DIV;
        shd_q  <= RST_DIV;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        div_q  <= div_d;
        shd_q  <= shd_d;
        pend_q <= pend_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with NUM_CH=2, CNT_W=8, DEFAULT_DIV=10.
module tb_clk_div_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] en = 2'b00;
  logic       sync = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [0:0] cfg_ch = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_ready;
  logic [1:0] clk_out;
  logic [1:0] tick;

  int n_cmp = 0;
  int n_bad = 0;

  clk_div_multi #(.NUM_CH(2), .CNT_W(8), .DEFAULT_DIV(10)) dut (
    .clk_100MHZ(clk),
    .rst(rst),
    .en(en),
    .sync(sync),
    .cfg_valid(cfg_valid),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_ready(cfg_ready),
    .clk_out(clk_out),
    .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] en;
    logic [1:0] clk;
    logic [1:0] tick;
    logic       rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [1:0] e, input logic [1:0] c, input logic [1:0] t, input int reps);
    vec_t v;
    v.en = e; v.clk = c; v.tick = t; v.rdy = 1'b1;
    for (int r = 0; r < reps; r++) tbl.push_back(v);
  endtask

  // Steps until tick[ch] is seen; n is the number of edges taken.
  task automatic wait_tick(input int ch, output int n);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      n++;
      if (tick[ch]) break;
    end
    if (!tick[ch]) check("wait_tick_timeout", 32'd0, 32'd1);
  endtask

  // Called on a tick sample: counts high samples and edges up to the next tick.
  task automatic measure(input int ch, input int eh, input int ep, input string nm);
    int hi;
    int per;
    bit found;
    hi = 1; per = 0; found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      step();
      per++;
      if (tick[ch]) found = 1'b1;
      else if (clk_out[ch]) hi++;
    end
    check({nm, "_high"}, hi, eh);
    check({nm, "_period"}, per, ep);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] ec, et;

    // Edges 1..33 after reset release; rows 23..25 disable ch0 mid-period.
    add(2'b11, 2'b00, 2'b00, 9);
    add(2'b11, 2'b11, 2'b11, 1);
    add(2'b11, 2'b11, 2'b00, 4);
    add(2'b11, 2'b00, 2'b00, 5);
    add(2'b11, 2'b11, 2'b11, 1);
    add(2'b11, 2'b11, 2'b00, 2);
    add(2'b10, 2'b11, 2'b00, 2);
    add(2'b10, 2'b01, 2'b00, 1);
    add(2'b11, 2'b01, 2'b00, 2);
    add(2'b11, 2'b00, 2'b00, 2);
    add(2'b11, 2'b10, 2'b10, 1);
    add(2'b11, 2'b10, 2'b00, 2);
    add(2'b11, 2'b11, 2'b01, 1);

    // Reset state, before any clock edge.
    #2 rst = 1'b1;
    #2;
    check("rst_clk_out", clk_out, 2'b00);
    check("rst_tick", tick, 2'b00);
    check("rst_cfg_ready", cfg_ready, 1'b1);
    step();
    step();
    rst = 1'b0;
    en = 2'b11;

    // Case 1 and 4: table-driven edges.
    foreach (tbl[k]) begin
      en = tbl[k].en;
      step();
      check($sformatf("tbl%0d_clk", k + 1), clk_out, tbl[k].clk);
      check($sformatf("tbl%0d_tick", k + 1), tick, tbl[k].tick);
      check($sformatf("tbl%0d_rdy", k + 1), cfg_ready, tbl[k].rdy);
    end

    // Case 2: ch1 <- 7 while its cnt is 3.
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd7;
    step();
    check("c2_rdy_low", cfg_ready, 1'b0);
    cfg_valid = 1'b0;
    step();
    check("c2_rdy_back", cfg_ready, 1'b1);
    check("c2_ch1_fell", clk_out[1], 1'b0);
    wait_tick(1, n);
    check("c2_old_period_rest", n, 5);
    measure(1, 4, 7, "c2_ch1_a");
    measure(1, 4, 7, "c2_ch1_b");
    wait_tick(0, n);
    measure(0, 5, 10, "c2_ch0");

    // Case 3: ch0 <- 0 behaves as 2.
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd0;
    step();
    check("c3_rdy_low", cfg_ready, 1'b0);
    cfg_valid = 1'b0;
    wait_tick(0, n);
    check("c3_old_period_rest", n, 9);
    measure(0, 1, 2, "c3_ch0");

    // Disabled channel loads its pending divisor on the next edge.
    en = 2'b01;
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd4;
    step();
    cfg_valid = 1'b0;
    step();
    check("dis_load_clk1", clk_out[1], 1'b0);
    check("dis_load_tick1", tick[1], 1'b0);
    en = 2'b11;
    wait_tick(1, n);
    check("dis_first_tick", n, 4);
    measure(1, 2, 4, "dis_ch1");

    // Case 5: sync realigns P=2 and P=4.
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_clk", clk_out, 2'b11);
    check("sync_tick", tick, 2'b11);
    for (int k = 1; k <= 8; k++) begin
      step();
      et = {1'((k % 4) == 0), 1'((k % 2) == 0)};
      ec = {1'((k % 4) == 0 || (k % 4) == 1), 1'((k % 2) == 0)};
      check($sformatf("align%0d_tick", k), tick, et);
      check($sformatf("align%0d_clk", k), clk_out, ec);
    end

    // Sync with ch1 disabled.
    en = 2'b01; sync = 1'b1;
    step();
    sync = 1'b0; en = 2'b11;
    check("sync_dis_clk", clk_out, 2'b01);
    check("sync_dis_tick", tick, 2'b01);

    // Write on the sync edge is not applied by that sync.
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd6; sync = 1'b1;
    step();
    cfg_valid = 1'b0; sync = 1'b0;
    check("sync_wr_tick", tick, 2'b11);
    check("sync_wr_rdy", cfg_ready, 1'b0);
    wait_tick(0, n);
    check("sync_wr_old_p", n, 2);
    measure(0, 3, 6, "sync_wr_ch0");

    // Pending write applied by a later sync.
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd3;
    step();
    cfg_valid = 1'b0; sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_load_tick1", tick[1], 1'b1);
    measure(1, 2, 3, "sync_load_ch1");

    // Case 6: async reset mid-period with a pending write.
    wait_tick(0, n);
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd5;
    step();
    cfg_valid = 1'b0;
    step();
    check("pre_rst_clk0", clk_out[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_clk", clk_out, 2'b00);
    check("async_rst_tick", tick, 2'b00);
    check("async_rst_rdy", cfg_ready, 1'b1);
    step();
    step();
    rst = 1'b0;
    wait_tick(0, n);
    check("post_rst_first", n, 10);
    check("post_rst_tick", tick, 2'b11);
    check("post_rst_clk", clk_out, 2'b11);
    measure(0, 5, 10, "post_rst_ch0");
    measure(1, 5, 10, "post_rst_ch1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
